// File: rtl/iob_cache_write_buffer_ctrl_pkg.sv
// Shared types, default sizes and entry-layout helpers for the cache write buffer.
package iob_cache_write_buffer_ctrl_pkg;

    localparam int WBUF_FE_ADDR_W = 32;
    localparam int WBUF_FE_DATA_W = 32;
    localparam int WBUF_DEPTH_W   = 2;

    // state        | meaning
    // WBUF_EMPTY   | level == 0, nothing to drain, no hazards possible
    // WBUF_PARTIAL | 0 < level < 2**DEPTH_W, push and pop both allowed
    // WBUF_FULL    | level == 2**DEPTH_W, pushes refused until a pop retires
    typedef enum logic [1:0] {
        WBUF_EMPTY   = 2'd0,
        WBUF_PARTIAL = 2'd1,
        WBUF_FULL    = 2'd2
    } wbuf_state_t;

    function automatic int wbuf_nbytes(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int wbuf_word_addr_w(input int addr_w, input int data_w);
        return addr_w - $clog2(data_w / 8);
    endfunction

    // Entry layout, MSB to LSB: {word addr, wdata, wstrb}
    function automatic int wbuf_entry_w(input int addr_w, input int data_w);
        return wbuf_word_addr_w(addr_w, data_w) + data_w + wbuf_nbytes(data_w);
    endfunction

endpackage

// File: rtl/iob_cache_wbuf_mem.sv
// Write-buffer storage: register array with one synchronous write port, one
// asynchronous read port, per-entry occupancy bits and all stored addresses.
module iob_cache_wbuf_mem
    import iob_cache_write_buffer_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 30,
    parameter int DATA_W  = 32,
    parameter int NBYTES  = 4,
    parameter int DEPTH_W = 2
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              we_i,
    input  logic [DEPTH_W-1:0]                waddr_i,
    input  logic [ADDR_W+DATA_W+NBYTES-1:0]   wentry_i,
    input  logic                              clr_i,
    input  logic [DEPTH_W-1:0]                clr_idx_i,
    input  logic [DEPTH_W-1:0]                raddr_i,
    output logic [ADDR_W+DATA_W+NBYTES-1:0]   rentry_o,
    output logic [(2**DEPTH_W)-1:0]           valid_o,
    output logic [(2**DEPTH_W)-1:0][ADDR_W-1:0] addr_o
);

    localparam int DEPTH   = 2 ** DEPTH_W;
    localparam int ENTRY_W = ADDR_W + DATA_W + NBYTES;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]   valid_q;
    logic [DEPTH-1:0]   valid_d;

    // Storage is never reset; occupancy bits alone decide what is live.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wentry_i;
        end
    end

    // Occupancy: cleared on the popped slot, set on the pushed slot.
    always_comb begin
        valid_d = valid_q;
        if (clr_i) begin
            valid_d[clr_idx_i] = 1'b0;
        end
        if (we_i) begin
            valid_d[waddr_i] = 1'b1;
        end
    end

    // Occupancy register with synchronous clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Head read and address fan-out for the hazard compare.
    always_comb begin
        rentry_o = mem_q[raddr_i];
        for (int i = 0; i < DEPTH; i++) begin
            addr_o[i] = mem_q[i][ENTRY_W-1 -: ADDR_W];
        end
    end

    assign valid_o = valid_q;

endmodule

// File: rtl/iob_cache_write_buffer_ctrl.sv
// Write-through buffer between cache front-end and AXI write back-end:
// in-order FIFO with first-word fall-through head and pending-address hazard check.
module iob_cache_write_buffer_ctrl
    import iob_cache_write_buffer_ctrl_pkg::*;
#(
    parameter int FE_ADDR_W = WBUF_FE_ADDR_W,
    parameter int FE_DATA_W = WBUF_FE_DATA_W,
    parameter int DEPTH_W   = WBUF_DEPTH_W
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   push_valid_i,
    input  logic [FE_ADDR_W-$clog2(FE_DATA_W/8)-1:0] push_addr_i,
    input  logic [FE_DATA_W-1:0]                   push_wdata_i,
    input  logic [FE_DATA_W/8-1:0]                 push_wstrb_i,
    output logic                                   push_ready_o,
    output logic                                   write_valid_o,
    output logic [FE_ADDR_W-$clog2(FE_DATA_W/8)-1:0] write_addr_o,
    output logic [FE_DATA_W-1:0]                   write_wdata_o,
    output logic [FE_DATA_W/8-1:0]                 write_wstrb_o,
    input  logic                                   write_ready_i,
    input  logic [FE_ADDR_W-$clog2(FE_DATA_W/8)-1:0] chk_addr_i,
    output logic                                   chk_hit_o,
    output logic                                   empty_o,
    output logic                                   full_o,
    output logic [DEPTH_W:0]                       level_o
);

    localparam int FE_NBYTES = wbuf_nbytes(FE_DATA_W);
    localparam int AW        = wbuf_word_addr_w(FE_ADDR_W, FE_DATA_W);
    localparam int ENTRY_W   = wbuf_entry_w(FE_ADDR_W, FE_DATA_W);
    localparam int DEPTH     = 2 ** DEPTH_W;
    localparam int LVL_W     = DEPTH_W + 1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    logic [DEPTH_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    wbuf_state_t        state;

    logic               push_fire;
    logic               pop_fire;
    logic [ENTRY_W-1:0] head_entry;
    logic [DEPTH-1:0]   occ;
    logic [DEPTH-1:0][AW-1:0] slot_addr;

    iob_cache_wbuf_mem #(
        .ADDR_W  (AW),
        .DATA_W  (FE_DATA_W),
        .NBYTES  (FE_NBYTES),
        .DEPTH_W (DEPTH_W)
    ) u_mem (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .we_i      (push_fire && !rst_i),
        .waddr_i   (wr_ptr_q),
        .wentry_i  ({push_addr_i, push_wdata_i, push_wstrb_i}),
        .clr_i     (pop_fire && !rst_i),
        .clr_idx_i (rd_ptr_q),
        .raddr_i   (rd_ptr_q),
        .rentry_o  (head_entry),
        .valid_o   (occ),
        .addr_o    (slot_addr)
    );

    // Occupancy state decoded from the level counter; drives the handshakes.
    always_comb begin
        state = WBUF_PARTIAL;
        if (level_q == '0) begin
            state = WBUF_EMPTY;
        end else if (level_q == LVL_FULL) begin
            state = WBUF_FULL;
        end
    end

    assign empty_o       = (state == WBUF_EMPTY);
    assign full_o        = (state == WBUF_FULL);
    assign push_ready_o  = !full_o;
    assign write_valid_o = !empty_o;
    assign level_o       = level_q;
    assign push_fire     = push_valid_i && push_ready_o;
    assign pop_fire      = write_valid_o && write_ready_i;

    assign write_addr_o  = head_entry[ENTRY_W-1 -: AW];
    assign write_wdata_o = head_entry[FE_NBYTES +: FE_DATA_W];
    assign write_wstrb_o = head_entry[FE_NBYTES-1:0];

    // Next pointers and level from the push/pop handshakes.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        level_d  = level_q;
        if (push_fire) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_fire) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_fire, pop_fire})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // Pointer and level registers; reset discards everything pending.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
        end
    end

    // Hazard: any live entry holding the checked word address.
    always_comb begin
        chk_hit_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (occ[i] && (slot_addr[i] == chk_addr_i)) begin
                chk_hit_o = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_iob_cache_write_buffer_ctrl.sv
// Directed vector table plus a randomized scoreboard run for the write buffer.
module tb_iob_cache_write_buffer_ctrl;

    localparam int AW = 30;

    typedef struct {
        logic        rst;
        logic        pv;
        logic [AW-1:0] pa;
        logic [31:0] pd;
        logic [3:0]  ps;
        logic        wr;
        logic [AW-1:0] ca;
        logic        chk;
        logic [2:0]  lv;
        logic [AW-1:0] wa;
        logic [31:0] wd;
        logic [3:0]  ws;
        logic        hit;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          push_valid;
    logic [AW-1:0] push_addr;
    logic [31:0]   push_wdata;
    logic [3:0]    push_wstrb;
    logic          push_ready;
    logic          write_valid;
    logic [AW-1:0] write_addr;
    logic [31:0]   write_wdata;
    logic [3:0]    write_wstrb;
    logic          write_ready;
    logic [AW-1:0] chk_addr;
    logic          chk_hit;
    logic          empty;
    logic          full;
    logic [2:0]    level;

    int checks = 0;
    int errors = 0;

    vec_t vecs[$];
    logic [AW+35:0] model[$];

    always #5 clk = ~clk;

    iob_cache_write_buffer_ctrl dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .push_valid_i  (push_valid),
        .push_addr_i   (push_addr),
        .push_wdata_i  (push_wdata),
        .push_wstrb_i  (push_wstrb),
        .push_ready_o  (push_ready),
        .write_valid_o (write_valid),
        .write_addr_o  (write_addr),
        .write_wdata_o (write_wdata),
        .write_wstrb_o (write_wstrb),
        .write_ready_i (write_ready),
        .chk_addr_i    (chk_addr),
        .chk_hit_o     (chk_hit),
        .empty_o       (empty),
        .full_o        (full),
        .level_o       (level)
    );

    function automatic void add(input int r, input int pv, input int pa, input logic [31:0] pd,
                                input int ps, input int wr, input int ca, input int chk,
                                input int lv, input int wa, input logic [31:0] wd, input int ws,
                                input int hit);
        vec_t v;
        v.rst = 1'(r);   v.pv = 1'(pv);  v.pa = AW'(pa); v.pd = pd;
        v.ps  = 4'(ps);  v.wr = 1'(wr);  v.ca = AW'(ca); v.chk = 1'(chk);
        v.lv  = 3'(lv);  v.wa = AW'(wa); v.wd = wd;      v.ws = 4'(ws);
        v.hit = 1'(hit);
        vecs.push_back(v);
    endfunction

    task automatic check_status(input string name, input logic [2:0] exp_lv, input logic exp_hit);
        logic [7:0] act, exp;
        act = {write_valid, push_ready, empty, full, level, chk_hit};
        exp = {exp_lv != 0, exp_lv != 4, exp_lv == 0, exp_lv == 4, exp_lv, exp_hit};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s status {wv,pr,em,fu,lvl,hit} actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic check_head(input string name, input logic [AW-1:0] wa, input logic [31:0] wd,
                              input logic [3:0] ws);
        checks++;
        if ({write_addr, write_wdata, write_wstrb} !== {wa, wd, ws}) begin
            errors++;
            $display("FAIL %s head actual=%h/%h/%h required=%h/%h/%h",
                     name, write_addr, write_wdata, write_wstrb, wa, wd, ws);
        end
    endtask

    initial begin
        int pops;
        int sz;
        logic exp_hit;
        logic [AW+35:0] h;

        rst = 1'b1; push_valid = 1'b0; push_addr = '0; push_wdata = '0;
        push_wstrb = '0; write_ready = 1'b0; chk_addr = '0;

        // T1 reset / idle
        add(1,0,0,0,0,0,0,        0, 0,0,0,0, 0);
        add(1,0,0,0,0,0,0,        1, 0,0,0,0, 0);
        add(0,0,0,0,0,0,0,        1, 0,0,0,0, 0);
        // T2 single write, then one-cycle pop
        add(0,1,'h10,'hDEADBEEF,'hF,0,'h10, 1, 0,0,0,0, 0);
        add(0,0,0,0,0,0,'h10,     1, 1,'h10,'hDEADBEEF,'hF, 1);
        add(0,0,0,0,0,1,'h10,     1, 1,'h10,'hDEADBEEF,'hF, 1);
        add(0,0,0,0,0,0,'h10,     1, 0,0,0,0, 0);
        // T3 fill to full, refused 5th push (also with a concurrent pop), ordered drain
        for (int i = 0; i < 4; i++) begin
            add(0,1,i,'hA0+i,1<<i,0,'h3F, 1, i,0,'hA0,1, 0);
        end
        add(0,1,4,'hA4,'hF,0,0,   1, 4,0,'hA0,1, 1);
        add(0,1,5,'hA5,'hF,1,3,   1, 4,0,'hA0,1, 1);
        add(0,0,0,0,0,1,0,        1, 3,1,'hA1,2, 0);
        add(0,0,0,0,0,1,3,        1, 2,2,'hA2,4, 1);
        add(0,0,0,0,0,1,3,        1, 1,3,'hA3,8, 1);
        add(0,0,0,0,0,0,4,        1, 0,0,0,0, 0);
        // T5 hazard on 0x20
        add(0,1,'h20,'h2020,'hC,0,'h20, 1, 0,0,0,0, 0);
        add(0,0,0,0,0,0,'h20,     1, 1,'h20,'h2020,'hC, 1);
        add(0,0,0,0,0,0,'h21,     1, 1,'h20,'h2020,'hC, 0);
        add(0,0,0,0,0,1,'h20,     1, 1,'h20,'h2020,'hC, 1);
        add(0,0,0,0,0,0,'h20,     1, 0,0,0,0, 0);
        // T6 reset with 3 pending, concurrent push/pop ignored
        for (int i = 0; i < 3; i++) begin
            add(0,1,'h30+i,'h300+i,'hF,0,'h31, 1, i,'h30,'h300,'hF, i > 1);
        end
        add(1,1,'h33,'h333,'hF,1,'h30, 1, 3,'h30,'h300,'hF, 1);
        add(0,0,0,0,0,0,'h30,     1, 0,0,0,0, 0);
        add(0,1,'h40,'h4040,'h3,0,'h33, 1, 0,0,0,0, 0);
        add(0,0,0,0,0,1,'h40,     1, 1,'h40,'h4040,'h3, 1);
        add(0,0,0,0,0,0,'h40,     1, 0,0,0,0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst = vecs[i].rst; push_valid = vecs[i].pv; push_addr = vecs[i].pa;
            push_wdata = vecs[i].pd; push_wstrb = vecs[i].ps;
            write_ready = vecs[i].wr; chk_addr = vecs[i].ca;
            #1;
            if (vecs[i].chk) begin
                check_status($sformatf("row%0d", i), vecs[i].lv, vecs[i].hit);
                if (vecs[i].lv != 0) begin
                    check_head($sformatf("row%0d", i), vecs[i].wa, vecs[i].wd, vecs[i].ws);
                end
            end
        end

        // T4 random push/pop against a queue model; buffer is empty here
        pops = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            rst         = 1'b0;
            push_valid  = 1'($urandom_range(0, 1));
            push_addr   = AW'($urandom_range(0, 15));
            push_wdata  = $urandom;
            push_wstrb  = 4'($urandom_range(1, 15));
            write_ready = 1'($urandom_range(0, 1));
            chk_addr    = AW'($urandom_range(0, 15));
            #1;
            sz = model.size();
            exp_hit = 1'b0;
            foreach (model[k]) begin
                if (model[k][AW+35:36] == chk_addr) exp_hit = 1'b1;
            end
            check_status($sformatf("rand%0d", c), 3'(sz), exp_hit);
            if (sz > 0) begin
                h = model[0];
                check_head($sformatf("rand%0d", c), h[AW+35:36], h[35:4], h[3:0]);
            end
            if (sz > 0 && write_ready) begin
                void'(model.pop_front());
                pops++;
            end
            if (push_valid && sz < 4) begin
                model.push_back({push_addr, push_wdata, push_wstrb});
            end
        end

        checks++;
        if (pops / 4 < 50) begin
            errors++;
            $display("FAIL wrap_count actual=%0d required>=50", pops / 4);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
